icache_responder: RTL and testbench

- Instruction-memory side of the fetch interface: takes the fetch address from the IF stage and returns the 32-bit instruction word.
- Raises `miss` to stall fetch whenever the word cannot be delivered in the same cycle.
- Direct-mapped, read-only instruction cache placed between the IF stage and main memory.
- Refills whole lines over a simple valid/ready request plus streamed-response memory port.

---
 rtl/icache_pkg.sv | 39 +++
 rtl/icache_tag_valid_array.sv | 41 ++++
 rtl/icache_responder.sv | 117 +++++++++++
 tb/tb_icache_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned DEF_NUM_LINES  = 64;
  localparam int unsigned DEF_ADDR_W     = 32;

  localparam int unsigned OFF_W = $clog2(DEF_LINE_WORDS) + 2;
  localparam int unsigned IDX_W = $clog2(DEF_NUM_LINES);
  localparam int unsigned TAG_W = DEF_ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  // Helpers work on a wide address; callers size-cast the result to the field width.
  typedef logic [63:0] addr_t;

  function automatic addr_t low_mask(input int unsigned n);
    return (addr_t'(1) << n) - addr_t'(1);
  endfunction

  function automatic addr_t addr_off(input addr_t a, input int unsigned off_w = OFF_W);
    return (a >> 2) & low_mask(off_w - 2);
  endfunction

  function automatic addr_t addr_idx(input addr_t a, input int unsigned off_w = OFF_W,
                                     input int unsigned idx_w = IDX_W);
    return (a >> off_w) & low_mask(idx_w);
  endfunction

  function automatic addr_t addr_tag(input addr_t a, input int unsigned off_w = OFF_W,
                                     input int unsigned idx_w = IDX_W);
    return a >> (off_w + idx_w);
  endfunction

  function automatic addr_t line_base(input addr_t a, input int unsigned off_w = OFF_W);
    return a & ~low_mask(off_w);
  endfunction

endpackage

// File: rtl/icache_tag_valid_array.sv
// Per-line valid bits (async reset, bulk clear) and tags; one write port, one combinational read.
module icache_tag_valid_array
  import icache_pkg::*;
#(
  parameter int unsigned IDX_BITS = IDX_W,
  parameter int unsigned TAG_BITS = TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic                wr_valid,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag
);

  localparam int unsigned LINES = 2 ** IDX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (clear) valid <= '0;
      if (wr_en) valid[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) tags[wr_idx] <= wr_tag;
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: zero-latency hits, whole-line refill over a req/stream port.
module icache_responder
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] Instr_address_2IM,
  output logic [31:0]       Instr1_fIM,
  output logic              miss,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
);

  localparam int unsigned WOFF_WIDTH = $clog2(LINE_WORDS);
  localparam int unsigned OFF_WIDTH  = WOFF_WIDTH + 2;
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_LINES);
  localparam int unsigned TAG_WIDTH  = ADDR_W - OFF_WIDTH - IDX_WIDTH;

  state_t                  state;
  logic [WOFF_WIDTH-1:0]   cnt;
  logic                    flush_pending;
  logic [ADDR_W-1:0]       fill_addr;

  logic [31:0]             data [NUM_LINES*LINE_WORDS];

  addr_t                   fetch_a, fill_a;
  logic [TAG_WIDTH-1:0]    tag, fill_tag, rd_tag;
  logic [IDX_WIDTH-1:0]    idx, fill_idx;
  logic [WOFF_WIDTH-1:0]   off;
  logic                    rd_valid, hit, last_beat, kill, clear_all;

  assign fetch_a  = addr_t'(Instr_address_2IM);
  assign fill_a   = addr_t'(fill_addr);
  assign tag      = TAG_WIDTH'(addr_tag(fetch_a, OFF_WIDTH, IDX_WIDTH));
  assign idx      = IDX_WIDTH'(addr_idx(fetch_a, OFF_WIDTH, IDX_WIDTH));
  assign off      = WOFF_WIDTH'(addr_off(fetch_a, OFF_WIDTH));
  assign fill_tag = TAG_WIDTH'(addr_tag(fill_a, OFF_WIDTH, IDX_WIDTH));
  assign fill_idx = IDX_WIDTH'(addr_idx(fill_a, OFF_WIDTH, IDX_WIDTH));

  assign last_beat = (state == FILL) && mem_resp_valid && (cnt == WOFF_WIDTH'(LINE_WORDS - 1));
  // A flush arriving on the last beat counts as pending: line written but left invalid.
  assign kill      = flush_pending || flush;
  assign clear_all = ((state == IDLE) && flush) || (last_beat && kill);

  icache_tag_valid_array #(
    .IDX_BITS (IDX_WIDTH),
    .TAG_BITS (TAG_WIDTH)
  ) u_tags (
    .clk      (CLK),
    .rst      (RESET),
    .clear    (clear_all),
    .wr_en    (last_beat),
    .wr_idx   (fill_idx),
    .wr_tag   (fill_tag),
    .wr_valid (!kill),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag)
  );

  assign hit          = rd_valid && (rd_tag == tag) && (state == IDLE);
  assign miss         = !hit;
  assign Instr1_fIM   = hit ? data[{idx, off}] : '0;
  assign mem_req_addr = fill_addr;

  always_ff @(posedge CLK) begin
    if ((state == FILL) && mem_resp_valid) data[{fill_idx, cnt}] <= mem_resp_data;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      cnt           <= '0;
      flush_pending <= 1'b0;
      fill_addr     <= '0;
      mem_req_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!hit) begin
            fill_addr     <= ADDR_W'(line_base(fetch_a, OFF_WIDTH));
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (flush) flush_pending <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= FILL;
          end
        end
        FILL: begin
          if (flush) flush_pending <= 1'b1;
          if (mem_resp_valid) begin
            cnt <= cnt + WOFF_WIDTH'(1);
            if (last_beat) begin
              flush_pending <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench: stimulus queues expected requests/words, a negedge monitor pops and compares.
module tb_icache_responder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] addr = 32'h0;
  logic [31:0] instr;
  logic        miss;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] req_q [$];
  logic [31:0] hit_q [$];
  bit          done = 1'b0;

  int ready_delay = 0;
  int beat_gap    = 0;
  int flush_beat  = -1;
  int reset_beat  = -1;

  icache_responder #(
    .LINE_WORDS (4),
    .NUM_LINES  (64),
    .ADDR_W     (32)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .Instr_address_2IM (addr),
    .Instr1_fIM        (instr),
    .miss              (miss),
    .flush             (flush),
    .mem_req_valid     (mem_req_valid),
    .mem_req_addr      (mem_req_addr),
    .mem_req_ready     (mem_req_ready),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  // Memory contents per line, hand-chosen.
  function automatic logic [31:0] mem_word(input logic [31:0] base, input int i);
    if (base == 32'hBFC00000) return 32'h11 * 32'(i + 1);
    if (base == 32'hBFC00400) return 32'hA1 + 32'(i);
    return (base + 32'(4 * i)) ^ 32'h5A5A0000;
  endfunction

  // Monitor
  always @(negedge CLK) begin
    if (!done) begin
      if (RESET) begin
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_miss", {31'b0, miss}, 32'd1);
        check("rst_instr", instr, 32'd0);
      end else begin
        if (mem_req_valid) begin
          if (req_q.size() == 0) fail("unexpected_req", mem_req_addr);
          else begin
            check("req_addr", mem_req_addr, req_q[0]);
            if (mem_req_ready) req_q.delete(0);
          end
        end
        if (!miss) begin
          if (hit_q.size() == 0) fail("unexpected_hit", instr);
          else begin
            check("hit_word", instr, hit_q[0]);
            hit_q.delete(0);
          end
        end else begin
          check("miss_instr_zero", instr, 32'd0);
        end
      end
    end
  end

  // Memory model
  initial begin
    logic [31:0] base;
    forever begin
      @(posedge CLK); #1;
      if (mem_req_valid && !RESET) begin
        base = mem_req_addr;
        repeat (ready_delay) begin @(posedge CLK); #1; end
        mem_req_ready = 1'b1;
        @(posedge CLK); #1;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          repeat (beat_gap) begin mem_resp_valid = 1'b0; @(posedge CLK); #1; end
          mem_resp_valid = 1'b1;
          mem_resp_data  = (reset_beat >= 0 && i > reset_beat) ? 32'hDEADBEEF : mem_word(base, i);
          flush          = (i == flush_beat);
          @(posedge CLK); #1;
          if (flush) flush_beat = -1;
          flush = 1'b0;
          if (reset_beat >= 0 && i == reset_beat) RESET = 1'b1;
          if (reset_beat >= 0 && i == reset_beat + 1) begin
            RESET = 1'b0;
            reset_beat = -1;
          end
        end
        mem_resp_valid = 1'b0;
      end
    end
  end

  task automatic wait_hit(output int unsigned m);
    m = 0;
    @(negedge CLK);
    while (miss && m < 100) begin
      m++;
      @(negedge CLK);
    end
    if (miss) fail("hit_timeout", addr);
    @(posedge CLK); #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] w, output int unsigned m);
    hit_q.push_back(w);
    addr = a;
    wait_hit(m);
  endtask

  initial begin
    int unsigned m;
    RESET = 1'b0;
    addr  = 32'hBFC00000;
    #2 RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    // 1: cold miss after reset
    req_q.push_back(32'hBFC00000);
    hit_q.push_back(32'h11);
    RESET = 1'b0;
    wait_hit(m);
    check("t1_miss_cycles", m, 32'd6);

    // 2: sequential hits
    fetch(32'hBFC00004, 32'h22, m); check("t2_lat_4", m, 32'd0);
    fetch(32'hBFC00008, 32'h33, m); check("t2_lat_8", m, 32'd0);
    fetch(32'hBFC0000C, 32'h44, m); check("t2_lat_c", m, 32'd0);

    // 3: conflict eviction
    req_q.push_back(32'hBFC00400);
    fetch(32'hBFC00400, 32'hA1, m); check("t3_miss_cycles", m, 32'd6);
    req_q.push_back(32'hBFC00000);
    fetch(32'hBFC00000, 32'h11, m); check("t3_refetch_cycles", m, 32'd6);

    // flush in IDLE: same-cycle lookup still hits, then the line is gone
    hit_q.push_back(32'h11);
    req_q.push_back(32'hBFC00000);
    hit_q.push_back(32'h11);
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    wait_hit(m);
    check("idle_flush_miss_cycles", m, 32'd6);

    // 4: slow ready and gapped beats
    ready_delay = 5;
    beat_gap    = 2;
    req_q.push_back(32'h00001230);
    fetch(32'h00001238, 32'h5A5A1238, m); check("t4_miss_cycles", m, 32'd19);
    ready_delay = 0;
    beat_gap    = 0;
    fetch(32'h00001230, 32'h5A5A1230, m); check("t4_lat_0", m, 32'd0);
    fetch(32'h00001234, 32'h5A5A1234, m); check("t4_lat_4", m, 32'd0);
    fetch(32'h0000123C, 32'h5A5A123C, m); check("t4_lat_c", m, 32'd0);

    // 5: flush during beat 2 leaves the line invalid and invalidates everything
    flush_beat = 2;
    req_q.push_back(32'h00002040);
    req_q.push_back(32'h00002040);
    fetch(32'h00002040, 32'h5A5A2040, m); check("t5_miss_cycles", m, 32'd12);
    req_q.push_back(32'hBFC00000);
    fetch(32'hBFC00008, 32'h33, m); check("t5_all_invalid", m, 32'd6);

    // 6: reset mid-fill with stray beats after release
    reset_beat = 1;
    req_q.push_back(32'h00003000);
    req_q.push_back(32'h00003000);
    fetch(32'h00003000, 32'h5A5A3000, m); check("t6_miss_cycles", m, 32'd12);
    req_q.push_back(32'hBFC00000);
    fetch(32'hBFC00004, 32'h22, m); check("t6_valid_cleared", m, 32'd6);

    done = 1'b1;
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("hit_q_drained", 32'(hit_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
